// File: rtl/mac_product_normalizer_if.sv
// Handshake and data bundle between the multiplier mid stage, the normalizer and the accumulator.
// The slave modport is the normalizer's view. The master modport is the surrounding datapath's view.
interface mac_product_normalizer_if;
    logic        i_valid;
    logic        i_ready;
    logic        i_sign;
    logic [4:0]  i_exp;
    logic [17:0] i_mant;
    logic        o_valid;
    logic        o_ready;
    logic        o_sign;
    logic [5:0]  o_exp;
    logic [7:0]  o_mant;
    logic        o_zero;
    logic        o_uflow;

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, o_ready,
        output i_ready, o_valid, o_sign, o_exp, o_mant, o_zero, o_uflow
    );

    modport master (
        output i_valid, i_sign, i_exp, i_mant, o_ready,
        input  i_ready, o_valid, o_sign, o_exp, o_mant, o_zero, o_uflow
    );
endinterface

// File: rtl/mac_product_normalizer.sv
// Two-stage normalizer for raw MAC mantissa products (leading-one detect, shift, round, flush).
// Define MAC_NORM_RNE_EN for round-to-nearest-even; otherwise discarded bits are truncated.
module mac_product_normalizer (
    input logic                     clk,
    input logic                     rst_n,
    mac_product_normalizer_if.slave bus
);
    logic        s1_valid_q, s1_sign_q;
    logic [4:0]  s1_exp_q, s1_pos_q;
    logic [17:0] s1_mant_q;
    logic        s2_valid_q, s2_sign_q, s2_zero_q, s2_uflow_q;
    logic [5:0]  s2_exp_q;
    logic [7:0]  s2_mant_q;

    logic        s1_adv, s2_adv;
    logic [4:0]  lead_pos;
    logic [4:0]  shift_amt;
    logic [7:0]  mant_norm, mant_rnd;
    logic        round_up, carry;
    logic signed [6:0] exp_full;
    logic        s2_sign_d, s2_zero_d, s2_uflow_d;
    logic [5:0]  s2_exp_d;
    logic [7:0]  s2_mant_d;

    assign s2_adv = !s2_valid_q || bus.o_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // Highest set bit wins; a zero mantissa leaves position 0 and is caught as o_zero later.
    always_comb begin
        lead_pos = '0;
        for (int k = 0; k < 18; k++) begin
            if (bus.i_mant[k]) lead_pos = 5'(k);
        end
    end

    always_comb begin
        shift_amt = s1_pos_q - 5'd7;
        if (s1_pos_q >= 5'd7) mant_norm = 8'(s1_mant_q >> shift_amt);
        else                  mant_norm = s1_mant_q[7:0] << (5'd7 - s1_pos_q);
    end

`ifdef MAC_NORM_RNE_EN
    logic [17:0] lost_bits;
    logic        guard, sticky;

    always_comb begin
        lost_bits = s1_mant_q & ~(18'h3FFFF << shift_amt);
        guard     = 1'b0;
        sticky    = 1'b0;
        if (s1_pos_q >= 5'd8) begin
            guard  = |(lost_bits & (18'd1 << (shift_amt - 5'd1)));
            sticky = |(lost_bits & ~(18'h3FFFF << (shift_amt - 5'd1)));
        end
        round_up = guard && (sticky || mant_norm[0]);
    end
`else
    assign round_up = 1'b0;
`endif

    // A carry out of 0xFF renormalizes to 0x80 and bumps the exponent; the flush test uses the bumped value.
    always_comb begin
        {carry, mant_rnd} = {1'b0, mant_norm} + {8'd0, round_up};
        if (carry) mant_rnd = 8'h80;
        exp_full = $signed({2'b00, s1_exp_q} + {2'b00, s1_pos_q} + {6'd0, carry} - 7'd7);

        s2_sign_d  = s1_sign_q;
        s2_exp_d   = exp_full[5:0];
        s2_mant_d  = mant_rnd;
        s2_zero_d  = 1'b0;
        s2_uflow_d = 1'b0;
        if (s1_mant_q == 18'd0) begin
            s2_sign_d = 1'b0;
            s2_exp_d  = '0;
            s2_mant_d = '0;
            s2_zero_d = 1'b1;
        end else if (exp_full < 0) begin
            s2_sign_d  = 1'b0;
            s2_exp_d   = '0;
            s2_mant_d  = '0;
            s2_zero_d  = 1'b1;
            s2_uflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_pos_q   <= '0;
            s1_mant_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_mant_q  <= '0;
            s2_zero_q  <= 1'b0;
            s2_uflow_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.i_valid;
                if (bus.i_valid) begin
                    s1_sign_q <= bus.i_sign;
                    s1_exp_q  <= bus.i_exp;
                    s1_pos_q  <= lead_pos;
                    s1_mant_q <= bus.i_mant;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sign_q  <= s2_sign_d;
                    s2_exp_q   <= s2_exp_d;
                    s2_mant_q  <= s2_mant_d;
                    s2_zero_q  <= s2_zero_d;
                    s2_uflow_q <= s2_uflow_d;
                end
            end
        end
    end

    assign bus.i_ready = s1_adv;
    assign bus.o_valid = s2_valid_q;
    assign bus.o_sign  = s2_sign_q;
    assign bus.o_exp   = s2_exp_q;
    assign bus.o_mant  = s2_mant_q;
    assign bus.o_zero  = s2_zero_q;
    assign bus.o_uflow = s2_uflow_q;
endmodule

// File: tb/tb_mac_product_normalizer.sv
// Directed bench for mac_product_normalizer: single beats, a stalled stream, and a mid-flight reset.
// Expected results are hand-computed; rounding cases follow MAC_NORM_RNE_EN.
module tb_mac_product_normalizer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mac_product_normalizer_if bus ();

    mac_product_normalizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] v_mant [10];
    logic [4:0]  v_exp  [10];
    logic        v_sign [10];
    logic [16:0] v_res  [10];   // {sign, exp[5:0], mant[7:0], zero, uflow}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int v);
        bus.i_mant = v_mant[v];
        bus.i_exp  = v_exp[v];
        bus.i_sign = v_sign[v];
    endtask

    function automatic logic [16:0] out_snap();
        return {bus.o_sign, bus.o_exp, bus.o_mant, bus.o_zero, bus.o_uflow};
    endfunction

    initial begin
        int  sent;
        int  recv;
        bit  got;
        bit  prev_stall;
        bit  stale;
        logic [16:0] snap;

        n_cmp = 0;
        n_err = 0;

        v_mant[0] = 18'h00080; v_exp[0] = 5'd10; v_sign[0] = 1'b1; v_res[0] = {1'b1, 6'd10, 8'h80, 1'b0, 1'b0};
        v_mant[1] = 18'h20000; v_exp[1] = 5'd5;  v_sign[1] = 1'b0; v_res[1] = {1'b0, 6'd15, 8'h80, 1'b0, 1'b0};
        v_mant[2] = 18'h001FF; v_exp[2] = 5'd3;  v_sign[2] = 1'b1;
`ifdef MAC_NORM_RNE_EN
        v_res[2] = {1'b1, 6'd5, 8'h80, 1'b0, 1'b0};
`else
        v_res[2] = {1'b1, 6'd4, 8'hFF, 1'b0, 1'b0};
`endif
        v_mant[3] = 18'h00000; v_exp[3] = 5'd9;  v_sign[3] = 1'b1; v_res[3] = {1'b0, 6'd0, 8'h00, 1'b1, 1'b0};
        v_mant[4] = 18'h00010; v_exp[4] = 5'd2;  v_sign[4] = 1'b1; v_res[4] = {1'b0, 6'd0, 8'h00, 1'b1, 1'b1};
        v_mant[5] = 18'h00001; v_exp[5] = 5'd7;  v_sign[5] = 1'b1; v_res[5] = {1'b1, 6'd0, 8'h80, 1'b0, 1'b0};
        v_mant[6] = 18'h3FFFF; v_exp[6] = 5'd31; v_sign[6] = 1'b0;
        v_mant[7] = 18'h00103; v_exp[7] = 5'd0;  v_sign[7] = 1'b1;
`ifdef MAC_NORM_RNE_EN
        v_res[6] = {1'b0, 6'd42, 8'h80, 1'b0, 1'b0};
        v_res[7] = {1'b1, 6'd1, 8'h82, 1'b0, 1'b0};
`else
        v_res[6] = {1'b0, 6'd41, 8'hFF, 1'b0, 1'b0};
        v_res[7] = {1'b1, 6'd1, 8'h81, 1'b0, 1'b0};
`endif
        v_mant[8] = 18'h00101; v_exp[8] = 5'd0;  v_sign[8] = 1'b0; v_res[8] = {1'b0, 6'd1, 8'h80, 1'b0, 1'b0};
        v_mant[9] = 18'h00035; v_exp[9] = 5'd9;  v_sign[9] = 1'b0; v_res[9] = {1'b0, 6'd7, 8'hD4, 1'b0, 1'b0};

        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        drive(0);
        #12;
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_outputs", out_snap(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_i_ready", bus.i_ready, 1);

        // Single beats with free-flowing output.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            bus.o_ready = 1'b1;
            bus.i_valid = 1'b1;
            drive(v);
            #1 chk($sformatf("v%0d_i_ready", v), bus.i_ready, 1);
            @(negedge clk);
            bus.i_valid = 1'b0;
            chk($sformatf("v%0d_no_early_valid", v), bus.o_valid, 0);
            got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                @(negedge clk);
                if (bus.o_valid) got = 1'b1;
            end
            chk($sformatf("v%0d_valid_seen", v), got, 1);
            if (got) chk($sformatf("v%0d_result", v), out_snap(), v_res[v]);
        end

        // Six back-to-back beats with o_ready low for three cycles mid-stream.
        sent = 0;
        recv = 0;
        prev_stall = 1'b0;
        snap = '0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            @(negedge clk);
            bus.o_ready = !(c >= 3 && c <= 5);
            bus.i_valid = (sent < 6);
            if (sent < 6) drive(sent);
            #1;
            chk($sformatf("bp_i_ready_c%0d", c), bus.i_ready, ((sent - recv) < 2) || bus.o_ready);
            if (prev_stall) chk($sformatf("bp_hold_c%0d", c), out_snap(), snap);
            prev_stall = bus.o_valid && !bus.o_ready;
            snap = out_snap();
            if (bus.o_valid && bus.o_ready) begin
                chk($sformatf("bp_out%0d", recv), out_snap(), v_res[recv]);
                recv++;
            end
            if (bus.i_valid && bus.i_ready) sent++;
        end
        chk("bp_all_received", recv, 6);
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1 chk("bp_no_duplicate", bus.o_valid, 0);

        // Reset with two beats held in the pipeline.
        @(negedge clk);
        bus.o_ready = 1'b0;
        bus.i_valid = 1'b1;
        drive(0);
        @(negedge clk);
        drive(9);
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("mid_rst_inflight", bus.o_valid, 1);
        chk("mid_rst_head", out_snap(), v_res[0]);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_o_valid", bus.o_valid, 0);
        chk("mid_rst_outputs", out_snap(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.o_ready = 1'b1;
        #1 chk("post_rst_i_ready", bus.i_ready, 1);
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.o_valid) stale = 1'b1;
        end
        chk("post_rst_no_stale", stale, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
